uart_tx_fifo_serializer: RTL and testbench
==========================================

UART_TX_FIFO_SERIALIZER -- requirements
Module: uart_tx_fifo_serializer

Interface
REQ-001 SHALL have parameter BYTES, default 4: bytes per input word, legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO depth in words, power of 2, minimum 2.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = byte 0 (tdata[7:0]) sent first; 0 = byte BYTES-1 sent first.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_axis_tdata  input  8*BYTES  input word.
REQ-007 s_axis_tkeep  input  BYTES  per-byte keep; bit i qualifies tdata[8i+7:8i].
REQ-008 s_axis_tvalid  input  1  input word valid.
REQ-009 s_axis_tready  output  1  module accepts a word this cycle.
REQ-010 tx_byte_ready  input  1  PHY accepts a byte this cycle.
REQ-011 tx_byte_data  output  8  byte to PHY.
REQ-012 tx_byte_valid  output  1  tx_byte_data valid.
REQ-013 fifo_level  output  $clog2(DEPTH+1)  words held in FIFO, excluding the word in the serializer.
REQ-014 busy  output  1  FIFO non-empty or serializer holding a word.

Function
REQ-015 Input transfer SHALL occur on a rising clk edge with s_axis_tvalid & s_axis_tready; the word and its tkeep SHALL be written to the FIFO tail.
REQ-016 s_axis_tready SHALL equal (fifo_level != DEPTH), decoded from registered state only; no combinational path from tx_byte_ready.
REQ-017 When the FIFO is full and the serializer pops in the same cycle, tready SHALL still be 0 that cycle; the slot frees the following cycle.
REQ-018 The serializer SHALL hold one word register, a remaining-keep mask and a state: IDLE or SEND.
REQ-019 IDLE -> SEND: at an edge where the FIFO is non-empty, pop the head word and load it with its keep mask.
REQ-020 In SEND, tx_byte_valid SHALL be 1, and tx_byte_data SHALL be the first still-set keep byte in send order (per LSB_FIRST).
REQ-021 Output transfer SHALL occur on an edge with tx_byte_valid & tx_byte_ready; that byte's mask bit SHALL then clear.
REQ-022 tx_byte_data and tx_byte_valid SHALL stay stable while tx_byte_valid=1 and tx_byte_ready=0.
REQ-023 On the transfer of the last kept byte, the serializer SHALL pop the next FIFO word in the same edge if one is present (stay SEND), else go to IDLE; no idle cycle between words.
REQ-024 Sustained throughput with tx_byte_ready held 1 SHALL be one byte per cycle.
REQ-025 A word with tkeep all zero SHALL be accepted, popped in one cycle, and SHALL produce no output byte.
REQ-026 Latency: a word accepted at edge k into an empty FIFO with the serializer IDLE SHALL show tx_byte_valid=1 after edge k+1.
REQ-027 A simultaneous FIFO write and pop SHALL leave fifo_level unchanged.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by the level count.
REQ-029 Data order SHALL be preserved: words in FIFO order, bytes within a word in send order.

Reset
REQ-030 While rst=1, the block SHALL clear the FIFO pointers and level, set the serializer to IDLE, and clear the mask.
REQ-031 Reset values SHALL be: s_axis_tready=0 while rst=1 and 1 after release; tx_byte_valid=0; tx_byte_data=8'h00; fifo_level=0; busy=0.
REQ-032 Reset mid-transfer SHALL discard all buffered and partially sent data; no byte SHALL appear after release unless new input is given.

Verification
REQ-033 BYTES=4, LSB_FIRST=1, tx_byte_ready=1: one word 32'h44332211 with tkeep=4'hF -> bytes 11,22,33,44 on consecutive cycles; first valid 2 cycles after accept.
REQ-034 Keep handling: tkeep=4'b0101 on 32'hDDCCBBAA -> bytes AA, CC only; next word tkeep=4'h0 -> no bytes; busy returns to 0.
REQ-035 DEPTH=4, tx_byte_ready=0: push words until tready=0 -> 4 words accepted into the FIFO (plus 1 in the serializer), fifo_level=4; hold one cycle of ready=1 -> tready rises one cycle after the word pop, not in the pop cycle.
REQ-036 Random tvalid/tready backpressure over 1000 words with random tkeep -> output stream equals the reference model of kept bytes in order; tx_byte_data stable while stalled.
REQ-037 LSB_FIRST=0: word 32'h44332211, tkeep=4'hF -> bytes 44,33,22,11.
REQ-038 Assert rst asynchronously mid-word (2 of 4 bytes sent, FIFO level 3) -> tx_byte_valid=0 and fifo_level=0 immediately; after release no output appears until a new word is sent.

Source files
------------

// File: rtl/uart_tx_fifo_serializer.sv
// Word-wide stream FIFO feeding a byte serializer that drops bytes whose keep bit is clear.
// Bytes leave in FIFO order and, within a word, in LSB-first or MSB-first order.
module uart_tx_fifo_serializer #(
  parameter int unsigned BYTES     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*BYTES-1:0]         s_axis_tdata,
  input  logic [BYTES-1:0]           s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       tx_byte_ready,
  output logic [7:0]                 tx_byte_data,
  output logic                       tx_byte_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // FIFO storage and bookkeeping
  logic [8*BYTES-1:0] mem_data_q [DEPTH];
  logic [BYTES-1:0]   mem_keep_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]    level_q, level_d;

  // Serializer
  state_e             state_q, state_d;
  logic [8*BYTES-1:0] word_q, word_d;
  logic [BYTES-1:0]   mask_q, mask_d;

  logic               push, pop, fifo_empty, fifo_full;
  logic               byte_xfer, need_word;
  logic [BYTES-1:0]   sel_oh, mask_rem;
  logic [7:0]         sel_byte;
  logic [8*BYTES-1:0] head_data;
  logic [BYTES-1:0]   head_keep;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LvlW'(DEPTH));
  assign head_data  = mem_data_q[rd_ptr_q];
  assign head_keep  = mem_keep_q[rd_ptr_q];

  // Ready depends only on the registered level; a same-cycle pop frees the slot next cycle.
  assign s_axis_tready = ~rst & ~fifo_full;
  assign push          = s_axis_tvalid & s_axis_tready;

  // Pick the first remaining kept byte in send order; the last match in the loop wins.
  always_comb begin
    sel_oh   = '0;
    sel_byte = 8'h00;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (LSB_FIRST) begin
        if (mask_q[BYTES-1-i]) begin
          sel_oh              = '0;
          sel_oh[BYTES-1-i]   = 1'b1;
          sel_byte            = word_q[8*(BYTES-1-i) +: 8];
        end
      end else begin
        if (mask_q[i]) begin
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
          sel_byte  = word_q[8*i +: 8];
        end
      end
    end
  end

  assign tx_byte_valid = (state_q == StSend);
  assign tx_byte_data  = (state_q == StSend) ? sel_byte : 8'h00;
  assign byte_xfer     = tx_byte_valid & tx_byte_ready;
  assign mask_rem      = mask_q & ~sel_oh;
  assign need_word     = (state_q == StIdle) | (byte_xfer & (mask_rem == '0));
  assign pop           = need_word & ~fifo_empty;

  assign fifo_level = level_q;
  assign busy       = ~fifo_empty | (state_q == StSend);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    if (byte_xfer) begin
      mask_d = mask_rem;
    end
    if (need_word) begin
      state_d = StIdle;
    end
    // A zero-keep word is consumed by the pop itself and never enters StSend.
    if (pop) begin
      word_d  = head_data;
      mask_d  = head_keep;
      state_d = (head_keep != '0) ? StSend : StIdle;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= StIdle;
      word_q   <= '0;
      mask_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      word_q   <= word_d;
      mask_q   <= mask_d;
    end
  end

  // Storage needs no reset; entries are only read once the level says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= s_axis_tdata;
      mem_keep_q[wr_ptr_q] <= s_axis_tkeep;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Bench for uart_tx_fifo_serializer: an LSB-first and an MSB-first instance share stimulus,
// each checked by a queue-based byte model plus directed timing checks.
module tb_uart_tx_fifo_serializer;

  localparam int unsigned BYTES = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [8*BYTES-1:0] tdata;
  logic [BYTES-1:0]  tkeep;
  logic              tvalid;
  logic              tx_ready;

  logic              l_tready, m_tready;
  logic [7:0]        l_data, m_data;
  logic              l_valid, m_valid;
  logic [LvlW-1:0]   l_level, m_level;
  logic              l_busy, m_busy;

  always #5 clk = ~clk;

  uart_tx_fifo_serializer #(.BYTES(BYTES), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (l_tready),
    .tx_byte_ready (tx_ready),
    .tx_byte_data  (l_data),
    .tx_byte_valid (l_valid),
    .fifo_level    (l_level),
    .busy          (l_busy)
  );

  uart_tx_fifo_serializer #(.BYTES(BYTES), .DEPTH(DEPTH), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (m_tready),
    .tx_byte_ready (tx_ready),
    .tx_byte_data  (m_data),
    .tx_byte_valid (m_valid),
    .fifo_level    (m_level),
    .busy          (m_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted word contributes its kept bytes, in send order.
  logic [7:0] exp_l[$];
  logic [7:0] exp_m[$];
  logic       l_stall_q, m_stall_q;
  logic [7:0] l_hold_q, m_hold_q;

  always @(posedge clk) begin
    if (rst) begin
      exp_l.delete();
      exp_m.delete();
      l_stall_q <= 1'b0;
      m_stall_q <= 1'b0;
    end else begin
      if (l_stall_q) begin
        check_eq("lsb_stall_valid", l_valid, 1);
        check_eq("lsb_stall_data", l_data, l_hold_q);
      end
      if (m_stall_q) begin
        check_eq("msb_stall_valid", m_valid, 1);
        check_eq("msb_stall_data", m_data, m_hold_q);
      end
      if (l_valid && tx_ready) begin
        if (exp_l.size() == 0) check_eq("lsb_unexpected_valid", l_valid, 0);
        else check_eq("lsb_byte", l_data, exp_l.pop_front());
      end
      if (m_valid && tx_ready) begin
        if (exp_m.size() == 0) check_eq("msb_unexpected_valid", m_valid, 0);
        else check_eq("msb_byte", m_data, exp_m.pop_front());
      end
      if (tvalid && l_tready) begin
        for (int i = 0; i < BYTES; i++) if (tkeep[i]) exp_l.push_back(tdata[8*i +: 8]);
      end
      if (tvalid && m_tready) begin
        for (int i = BYTES - 1; i >= 0; i--) if (tkeep[i]) exp_m.push_back(tdata[8*i +: 8]);
      end
      l_stall_q <= l_valid && !tx_ready;
      m_stall_q <= m_valid && !tx_ready;
      l_hold_q  <= l_data;
      m_hold_q  <= m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic push(input logic [31:0] d, input logic [3:0] k);
    int n;
    n = 0;
    tdata  = d;
    tkeep  = k;
    tvalid = 1'b1;
    while (!l_tready && n < 200) begin
      step();
      n++;
    end
    if (!l_tready) begin
      check_eq("push_timeout", l_tready, 1);
      tvalid = 1'b0;
      return;
    end
    step();
    tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!l_busy && !m_busy) return;
      step();
    end
    check_eq("drain_busy", {l_busy, m_busy}, 0);
  endtask

  logic [7:0] seq_l [4];
  logic [7:0] seq_m [4];
  logic       push_done;
  logic       prev_rdy;
  int         accepted;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    tdata    = '0;
    tkeep    = '0;
    tvalid   = 1'b0;
    tx_ready = 1'b0;
    push_done = 1'b0;
    #2;
    check_eq("rst_tready", {l_tready, m_tready}, 0);
    check_eq("rst_valid", {l_valid, m_valid}, 0);
    check_eq("rst_data", {l_data, m_data}, 0);
    check_eq("rst_level", {l_level, m_level}, 0);
    check_eq("rst_busy", {l_busy, m_busy}, 0);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_eq("tready_after_rst", {l_tready, m_tready}, 2'b11);
    step();

    // Full word, both byte orders, one byte per cycle, valid two edges after accept.
    tx_ready = 1'b1;
    seq_l = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq_m = '{8'h44, 8'h33, 8'h22, 8'h11};
    push(32'h44332211, 4'hF);
    check_eq("latency_not_yet", {l_valid, m_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("full_valid", {l_valid, m_valid}, 2'b11);
      check_eq("full_lsb_byte", l_data, seq_l[i]);
      check_eq("full_msb_byte", m_data, seq_m[i]);
    end
    step();
    check_eq("full_done_valid", {l_valid, m_valid}, 0);
    check_eq("full_done_busy", {l_busy, m_busy}, 0);

    // Sparse keep followed by an empty-keep word.
    push(32'hDDCCBBAA, 4'b0101);
    push(32'h12345678, 4'h0);
    check_eq("keep_lsb_b0", l_data, 8'hAA);
    check_eq("keep_msb_b0", m_data, 8'hCC);
    step();
    check_eq("keep_lsb_b1", l_data, 8'hCC);
    check_eq("keep_msb_b1", m_data, 8'hAA);
    step();
    check_eq("keep0_no_byte", {l_valid, m_valid}, 0);
    check_eq("keep0_busy", {l_busy, m_busy}, 0);
    step();

    // Fill with the PHY stalled, then release one byte to pop a word while full.
    tx_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      tdata    = $urandom;
      tkeep    = (accepted == 0) ? 4'h1 : 4'hF;
      tvalid   = 1'b1;
      prev_rdy = l_tready;
      step();
      if (prev_rdy) accepted++;
      if (!l_tready) break;
    end
    tvalid = 1'b0;
    check_eq("fill_accepted", accepted, 5);
    check_eq("fill_level", l_level, 4);
    check_eq("fill_tready", {l_tready, m_tready}, 0);
    check_eq("fill_valid", {l_valid, m_valid}, 2'b11);
    tx_ready = 1'b1;
    check_eq("pop_cycle_tready", {l_tready, m_tready}, 0);
    step();
    tx_ready = 1'b0;
    check_eq("after_pop_level", l_level, 3);
    check_eq("after_pop_tready", {l_tready, m_tready}, 2'b11);
    step();
    tx_ready = 1'b1;
    wait_idle(100);

    // Reset with two bytes of a word sent and three words queued.
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push($urandom, 4'hF);
    check_eq("pre_rst_level", l_level, 3);
    tx_ready = 1'b1;
    step();
    step();
    tx_ready = 1'b0;
    check_eq("pre_rst_valid", {l_valid, m_valid}, 2'b11);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", {l_valid, m_valid}, 0);
    check_eq("mid_rst_level", {l_level, m_level}, 0);
    check_eq("mid_rst_tready", {l_tready, m_tready}, 0);
    step();
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("post_rst_quiet", {l_valid, m_valid, l_busy, m_busy}, 0);
    end

    // Random words, random keep, random gaps and PHY backpressure.
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          repeat ($urandom_range(0, 2)) step();
          push($urandom, 4'($urandom_range(0, 15)));
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          tx_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    tx_ready = 1'b1;
    wait_idle(200);
    step();
    check_eq("lsb_leftover", exp_l.size(), 0);
    check_eq("msb_leftover", exp_m.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
